noc_packetizer: RTL and testbench

NOC_PACKETIZER -- requirements
Module: noc_packetizer

---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_credit_counter.sv | 51 +++++
 rtl/noc_packetizer.sv | 129 ++++++++++++
 tb/tb_noc_packetizer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and width helpers for the NoC packetizer and its credit counter.
package noc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } pkt_state_e;

  // Width needed to hold a credit count in the range 0..depth.
  function automatic int credit_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Tracks free slots in the downstream router buffer; saturates and flags
// a sticky error when more credits come back than the buffer can hold.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          consume,
  input  logic          credit_in,
  output logic [CW-1:0] count,
  output logic          available,
  output logic          overflow
);

  localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(DEPTH);

  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;
  logic [CW:0]   sum;
  logic          use_credit;

  always_comb begin
    use_credit = consume && (count_reg != '0);
    // One extra bit so a returned credit at full count is visible as overflow.
    sum        = {1'b0, count_reg} - {{CW{1'b0}}, use_credit} + {{CW{1'b0}}, credit_in};
    count_next = sum[CW-1:0];
    err_next   = err_reg;
    if (sum > DEPTH_EXT) begin
      count_next = DEPTH_EXT[CW-1:0];
      err_next   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= DEPTH_EXT[CW-1:0];
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count     = count_reg;
  assign available = (count_reg != '0);
  assign overflow  = err_reg;

endmodule

// File: rtl/noc_packetizer.sv
// Splits an offered packet into flits for a router local port, pacing
// emission with credit-based flow control from the router input buffer.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter  int DEST_WIDTH        = 4,
  parameter  int FLIT_WIDTH        = 256,
  parameter  int FLIT_BUFFER_DEPTH = 2,
  parameter  int MAX_FLITS         = 4,
  localparam int LEN_WIDTH         = $clog2(MAX_FLITS + 1),
  localparam int CW                = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [MAX_FLITS*FLIT_WIDTH-1:0] pkt_data,
  input  logic [DEST_WIDTH-1:0]           pkt_dest,
  input  logic [LEN_WIDTH-1:0]            pkt_len,
  input  logic                            pkt_valid,
  output logic                            pkt_ready,
  output logic [FLIT_WIDTH-1:0]           data_out,
  output logic [DEST_WIDTH-1:0]           dest_out,
  output logic                            is_tail_out,
  output logic                            send_out,
  input  logic                            credit_in,
  output logic                            credit_err
);

  localparam int                   IDX_W   = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FLITS);

  pkt_state_e             state_reg, state_next;
  logic [LEN_WIDTH-1:0]   flit_idx_reg, flit_idx_next;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [DEST_WIDTH-1:0]  dest_reg;
  logic [LEN_WIDTH-1:0]   len_eff;
  logic [IDX_W-1:0]       idx_sel;
  logic [FLIT_WIDTH-1:0]  flit_view [MAX_FLITS];
  logic                   accept, capture, tail_now;
  logic [CW-1:0]          credit_cnt;
  logic                   credit_avail;

  noc_credit_counter #(
    .DEPTH(FLIT_BUFFER_DEPTH)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .consume  (send_out),
    .credit_in(credit_in),
    .count    (credit_cnt),
    .available(credit_avail),
    .overflow (credit_err)
  );

  assign len_eff     = (pkt_len > MAX_LEN) ? MAX_LEN : pkt_len;
  assign send_out    = (state_reg == SEND) && credit_avail;
  assign tail_now    = (flit_idx_reg == (len_reg - LEN_WIDTH'(1)));
  assign is_tail_out = send_out && tail_now;
  assign pkt_ready   = (state_reg == IDLE) || is_tail_out;
  assign accept      = pkt_valid && pkt_ready;
  // Zero-length packets are consumed without touching any captured state.
  assign capture     = accept && (len_eff != '0);

  always_comb begin
    state_next    = state_reg;
    flit_idx_next = flit_idx_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          state_next    = SEND;
          flit_idx_next = '0;
        end
      end
      SEND: begin
        if (send_out) begin
          if (tail_now) begin
            // Index stays on the tail flit so data_out holds while idle.
            state_next = capture ? SEND : IDLE;
            if (capture) begin
              flit_idx_next = '0;
            end
          end else begin
            flit_idx_next = flit_idx_reg + LEN_WIDTH'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      flit_idx_reg <= '0;
      len_reg      <= '0;
      dest_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      flit_idx_reg <= flit_idx_next;
      if (capture) begin
        len_reg  <= len_eff;
        dest_reg <= pkt_dest;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_flit
      logic [FLIT_WIDTH-1:0] flit_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          flit_reg <= '0;
        end else if (capture) begin
          flit_reg <= pkt_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end
      end

      assign flit_view[gi] = flit_reg;
    end
  endgenerate

  assign idx_sel  = flit_idx_reg[IDX_W-1:0];
  assign data_out = flit_view[idx_sel];
  assign dest_out = dest_reg;

  a_credit_view : assert property (@(posedge clk) disable iff (!rst_n)
    credit_avail == (credit_cnt != '0));

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: fixed vector table, directed corner sequences and
// a randomized run, all checked against a queue-based flit model.
module tb_noc_packetizer;

  localparam int DW    = 4;
  localparam int FW    = 256;
  localparam int DEPTH = 2;
  localparam int MF    = 4;
  localparam int LW    = $clog2(MF + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [MF*FW-1:0]  pkt_data;
  logic [DW-1:0]     pkt_dest;
  logic [LW-1:0]     pkt_len;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [FW-1:0]     data_out;
  logic [DW-1:0]     dest_out;
  logic              is_tail_out;
  logic              send_out;
  logic              credit_in;
  logic              credit_err;

  noc_packetizer #(
    .DEST_WIDTH       (DW),
    .FLIT_WIDTH       (FW),
    .FLIT_BUFFER_DEPTH(DEPTH),
    .MAX_FLITS        (MF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkt_data   (pkt_data),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .data_out   (data_out),
    .dest_out   (dest_out),
    .is_tail_out(is_tail_out),
    .send_out   (send_out),
    .credit_in  (credit_in),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  // Reference model: pending flits of accepted packets plus a credit tally.
  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    bit            tail;
  } flit_t;

  flit_t         mq[$];
  int            m_cred;
  bit            m_err;
  logic [FW-1:0] m_hdata;
  logic [DW-1:0] m_hdest;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit obs_send, obs_tail, obs_ready;

  typedef struct {
    bit v;
    int len;
    int dest;
    bit cr;
    bit e_send;
    bit e_tail;
    bit e_ready;
  } vec_t;

  vec_t tbl[$];

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cred  = DEPTH;
    m_err   = 1'b0;
    m_hdata = '0;
    m_hdest = '0;
  endtask

  task automatic check_outputs();
    bit            e_send, e_tail, e_ready;
    logic [FW-1:0] e_data;
    logic [DW-1:0] e_dest;
    e_send  = (mq.size() > 0) && (m_cred > 0);
    e_tail  = 1'b0;
    e_data  = m_hdata;
    e_dest  = m_hdest;
    if (mq.size() > 0) begin
      e_data = mq[0].data;
      e_dest = mq[0].dest;
      e_tail = e_send && mq[0].tail;
    end
    e_ready = (mq.size() == 0) || e_tail;
    obs_send  = send_out;
    obs_tail  = is_tail_out;
    obs_ready = pkt_ready;
    if (chk_en) begin
      check_int("send_out", int'(send_out), int'(e_send));
      check_int("is_tail_out", int'(is_tail_out), int'(e_tail));
      check_int("pkt_ready", int'(pkt_ready), int'(e_ready));
      check_data("data_out", data_out, e_data);
      check_int("dest_out", int'(dest_out), int'(e_dest));
      check_int("credit_err", int'(credit_err), int'(m_err));
      check_int("credit_cnt", int'(dut.credit_cnt), m_cred);
    end
  endtask

  task automatic model_update();
    bit    snd, rdy;
    int    c, l;
    flit_t f;
    if (!rst_n) begin
      model_reset();
      $display("[TB] reset");
      return;
    end
    snd = (mq.size() > 0) && (m_cred > 0);
    rdy = (mq.size() == 0) || (snd && mq[0].tail);
    if (snd) begin
      f = mq.pop_front();
      m_hdata = f.data;
      m_hdest = f.dest;
    end
    c = m_cred - int'(snd) + int'(credit_in);
    if (c > DEPTH) begin
      c = DEPTH;
      m_err = 1'b1;
    end
    m_cred = c;
    if (pkt_valid && rdy) begin
      l = int'(pkt_len);
      if (l > MF) l = MF;
      for (int k = 0; k < l; k++) begin
        f.data = pkt_data[k*FW +: FW];
        f.dest = pkt_dest;
        f.tail = (k == l - 1);
        mq.push_back(f);
      end
      $display("[TB] accept dest=%0d len=%0d flits=%0d", pkt_dest, pkt_len, l);
    end
  endtask

  task automatic cycle(input bit rst, input bit v, input int len, input int dest, input bit cr);
    rst_n     = !rst;
    pkt_valid = v;
    pkt_len   = LW'(len);
    pkt_dest  = DW'(dest);
    credit_in = cr;
    for (int k = 0; k < MF * FW / 32; k++) pkt_data[k*32 +: 32] = $urandom();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    int sends;
    bit prev_send;

    rst_n = 1'b0; pkt_valid = 1'b0; pkt_len = '0; pkt_dest = '0;
    credit_in = 1'b0; pkt_data = '0;
    model_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    idle(1);

    // 3 flits to dest 5 with credits returned one cycle after each send;
    // back-to-back single-flit packets; zero-length then oversize packet.
    tbl.push_back('{1, 3, 5, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 3, 0, 0, 0, 1});
    tbl.push_back('{1, 1, 9, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 0, 2, 0, 0, 0, 1});
    tbl.push_back('{1, 7, 6, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 1, 1});
    tbl.push_back('{0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1});
    foreach (tbl[i]) begin
      cycle(0, tbl[i].v, tbl[i].len, tbl[i].dest, tbl[i].cr);
      check_int($sformatf("tbl%0d_send", i), int'(obs_send), int'(tbl[i].e_send));
      check_int($sformatf("tbl%0d_tail", i), int'(obs_tail), int'(tbl[i].e_tail));
      check_int($sformatf("tbl%0d_ready", i), int'(obs_ready), int'(tbl[i].e_ready));
    end

    // Credit starvation: two flits go, then stall until credits return.
    cycle(0, 1, 4, 7, 0);
    sends = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0);
      sends += int'(obs_send);
    end
    check_int("stall_sends", sends, 2);
    cycle(0, 0, 0, 0, 1);
    check_int("pulse1_same_cycle", int'(obs_send), 0);
    cycle(0, 0, 0, 0, 0);
    check_int("flit3_after_pulse", int'(obs_send), 1);
    cycle(0, 0, 0, 0, 0);
    check_int("stall_again", int'(obs_send), 0);
    cycle(0, 0, 0, 0, 1);
    check_int("pulse2_same_cycle", int'(obs_send), 0);
    cycle(0, 0, 0, 0, 0);
    check_int("flit4_after_pulse", int'(obs_send), 1);
    check_int("flit4_tail", int'(obs_tail), 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    idle(1);

    // Credit returned while already full: saturate and latch the error.
    cycle(0, 0, 0, 0, 1);
    idle(3);
    check_int("ovf_cnt", int'(dut.credit_cnt), DEPTH);
    check_int("ovf_err", int'(credit_err), 1);
    cycle(1, 0, 0, 0, 0);
    idle(1);
    check_int("err_cleared", int'(credit_err), 0);

    // Reset lands on the edge that ends the second flit of a 4-flit packet.
    cycle(0, 1, 4, 3, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1);
    sends = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      sends += int'(obs_send);
    end
    check_int("abort_sends", sends, 0);
    check_int("abort_cnt", int'(dut.credit_cnt), DEPTH);
    cycle(0, 1, 2, 12, 0);
    idle(4);

    // Randomized traffic; credits partly follow sends, partly random.
    prev_send = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit rst, v, cr;
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 1) == 1);
      cr  = prev_send ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      cycle(rst, v, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), cr);
      prev_send = obs_send;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
